// File: rtl/serial_nibble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_nibble_pkg
// Brief    : Shared defaults and types for the serial nibble deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_nibble_pkg;

    localparam int NBITS_DEFAULT  = 4;
    localparam int QDEPTH_DEFAULT = 2;

    typedef logic [3:0] nibble_t;

endpackage : serial_nibble_pkg
`default_nettype wire

// File: rtl/serial_nibble_queue.sv
`default_nettype none
// ============================================================================
// Module   : serial_nibble_queue
// Brief    : Small val/rdy FIFO; a full queue still accepts a write when the
//            head leaves in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module serial_nibble_queue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [WIDTH-1:0] enq_msg,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [WIDTH-1:0] deq_msg
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_enq;
    logic w_deq;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign deq_val = (r_count != '0);
    assign enq_rdy = !w_full || deq_rdy;
    assign w_enq   = enq_val && enq_rdy;
    assign w_deq   = deq_val && deq_rdy;
    // Head is masked so an empty queue presents zero rather than stale data.
    assign deq_msg = deq_val ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= enq_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : serial_nibble_queue
`default_nettype wire

// File: rtl/serial_nibble_deser.sv
`default_nettype none
// ============================================================================
// Module   : serial_nibble_deser
// Brief    : LSB-first serial-to-nibble assembler with frame sync, output
//            queue and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module serial_nibble_deser
    import serial_nibble_pkg::*;
#(
    parameter int NBITS  = NBITS_DEFAULT,
    parameter int QDEPTH = QDEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    input  logic                     in_bit,
    input  logic                     in_sync,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [NBITS-1:0]         out_,
    output logic                     overrun,
    output logic [$clog2(NBITS)-1:0] bitcnt
);

    localparam int                c_CW   = $clog2(NBITS);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(NBITS - 1);

    logic [NBITS-1:0] r_shreg;
    logic [c_CW-1:0]  r_bitcnt;
    logic             r_overrun;

    logic             w_complete;
    logic             w_enq_rdy;
    logic [NBITS-1:0] w_word;

    // A sync pulse restarts the word, so it can never complete one.
    assign w_complete = in_val && !in_sync && (r_bitcnt == c_LAST);

    always_comb begin
        w_word            = r_shreg;
        w_word[NBITS-1]   = in_bit;
    end

    serial_nibble_queue #(
        .WIDTH (NBITS),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (w_complete),
        .enq_rdy (w_enq_rdy),
        .enq_msg (w_word),
        .deq_val (out_val),
        .deq_rdy (out_rdy),
        .deq_msg (out_)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete && !w_enq_rdy) begin
                r_overrun <= 1'b1;
            end
            if (in_sync) begin
                if (in_val) begin
                    r_shreg[0] <= in_bit;
                    r_bitcnt   <= c_CW'(1);
                end else begin
                    r_bitcnt   <= '0;
                end
            end else if (in_val) begin
                r_shreg[r_bitcnt] <= in_bit;
                r_bitcnt          <= w_complete ? '0 : (r_bitcnt + c_CW'(1));
            end
        end
    end

    assign overrun = r_overrun;
    assign bitcnt  = r_bitcnt;

endmodule : serial_nibble_deser
`default_nettype wire

// File: tb/tb_serial_nibble_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_nibble_deser
// Brief    : Table, directed and random checks of serial_nibble_deser against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_nibble_deser;
    import serial_nibble_pkg::*;

    localparam int NB = 4;
    localparam int QD = 2;

    logic       clk = 1'b0;
    logic       reset, in_val, in_bit, in_sync, out_rdy;
    logic       out_val, overrun;
    logic [3:0] out_;
    logic [1:0] bitcnt;

    always #5 clk = ~clk;

    serial_nibble_deser #(.NBITS(NB), .QDEPTH(QD)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_bit  (in_bit),
        .in_sync (in_sync),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_    (out_),
        .overrun (overrun),
        .bitcnt  (bitcnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words waiting downstream, bits of the word in progress.
    nibble_t m_q[$];
    bit      m_bits[$];
    bit      m_ovr;

    typedef struct {
        logic       r, v, b, s, rdy;
        logic       ev;
        logic [3:0] eo;
        logic       eovr;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic r, logic v, logic b, logic s, logic rdy,
                                logic ev, logic [3:0] eo, logic eovr, logic [1:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.s = s; t.rdy = rdy;
        t.ev = ev; t.eo = eo; t.eovr = eovr; t.ec = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit b, input bit s, input bit rdy);
        bit      deq;
        bit      done;
        nibble_t w;
        done = 1'b0;
        w    = '0;
        if (r) begin
            m_q.delete();
            m_bits.delete();
            m_ovr = 1'b0;
        end else begin
            deq = (m_q.size() > 0) && rdy;
            if (s) begin
                m_bits.delete();
                if (v) m_bits.push_back(b);
            end else if (v) begin
                m_bits.push_back(b);
                if (m_bits.size() == NB) begin
                    for (int i = 0; i < NB; i++) w[i] = m_bits[i];
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            if (deq) void'(m_q.pop_front());
            if (done) begin
                if (m_q.size() < QD) m_q.push_back(w);
                else                 m_ovr = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit s, input bit rdy);
        nibble_t exp_out;
        reset = r; in_val = v; in_bit = b; in_sync = s; out_rdy = rdy;
        @(posedge clk);
        model_edge(r, v, b, s, rdy);
        #1;
        exp_out = (m_q.size() > 0) ? m_q[0] : 4'h0;
        check("model.out_val", 8'(out_val), 8'(m_q.size() > 0));
        check("model.out_",    8'(out_),    8'(exp_out));
        check("model.overrun", 8'(overrun), 8'(m_ovr));
        check("model.bitcnt",  8'(bitcnt),  8'(m_bits.size()));
    endtask

    task automatic send_word(input nibble_t w, input bit rdy);
        for (int i = 0; i < NB; i++) step(0, 1, w[i], 0, rdy);
    endtask

    initial begin
        nibble_t words [4];
        nibble_t w;
        nibble_t w4;

        tbl[0]  = mk(1,0,0,0,1, 0,4'h0,0,0);
        tbl[1]  = mk(0,1,1,0,1, 0,4'h0,0,1);
        tbl[2]  = mk(0,1,1,0,1, 0,4'h0,0,2);
        tbl[3]  = mk(1,1,1,0,1, 0,4'h0,0,0);
        tbl[4]  = mk(0,1,1,0,1, 0,4'h0,0,1);
        tbl[5]  = mk(0,1,0,0,1, 0,4'h0,0,2);
        tbl[6]  = mk(0,1,1,0,1, 0,4'h0,0,3);
        tbl[7]  = mk(0,1,1,0,1, 1,4'hD,0,0);
        tbl[8]  = mk(0,0,0,0,1, 0,4'h0,0,0);
        tbl[9]  = mk(0,1,1,0,1, 0,4'h0,0,1);
        tbl[10] = mk(0,0,0,0,1, 0,4'h0,0,1);
        tbl[11] = mk(0,1,1,0,1, 0,4'h0,0,2);
        tbl[12] = mk(0,0,1,0,1, 0,4'h0,0,2);
        tbl[13] = mk(0,1,0,0,1, 0,4'h0,0,3);
        tbl[14] = mk(0,0,0,0,1, 0,4'h0,0,3);
        tbl[15] = mk(0,1,0,0,1, 1,4'h3,0,0);
        tbl[16] = mk(0,0,0,0,1, 0,4'h0,0,0);
        tbl[17] = mk(0,1,1,0,1, 0,4'h0,0,1);
        tbl[18] = mk(0,1,1,0,1, 0,4'h0,0,2);
        tbl[19] = mk(0,1,0,1,1, 0,4'h0,0,1);
        tbl[20] = mk(0,1,1,0,1, 0,4'h0,0,2);
        tbl[21] = mk(0,1,0,0,1, 0,4'h0,0,3);
        tbl[22] = mk(0,1,1,0,1, 1,4'hA,0,0);
        tbl[23] = mk(0,0,0,0,1, 0,4'h0,0,0);
        tbl[24] = mk(0,1,1,0,1, 0,4'h0,0,1);
        tbl[25] = mk(0,0,0,1,1, 0,4'h0,0,0);
        tbl[26] = mk(0,0,0,0,1, 0,4'h0,0,0);

        reset = 1'b1; in_val = 1'b0; in_bit = 1'b0; in_sync = 1'b0; out_rdy = 1'b0;

        // Reset, gaps, sync realignment with hand-derived expectations.
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].rdy);
            check($sformatf("tbl%0d.out_val", i), 8'(out_val), 8'(tbl[i].ev));
            check($sformatf("tbl%0d.out_",    i), 8'(out_),    8'(tbl[i].eo));
            check($sformatf("tbl%0d.overrun", i), 8'(overrun), 8'(tbl[i].eovr));
            check($sformatf("tbl%0d.bitcnt",  i), 8'(bitcnt),  8'(tbl[i].ec));
        end

        // Back-to-back words with in_val held high.
        words[0] = 4'h0; words[1] = 4'h5; words[2] = 4'hA; words[3] = 4'hF;
        for (int k = 0; k < 16; k++) begin
            w = words[k / 4];
            step(0, 1, w[k % 4], 0, 1);
            check($sformatf("b2b%0d.out_val", k), 8'(out_val), 8'((k % 4) == 3));
            check($sformatf("b2b%0d.out_", k), 8'(out_), ((k % 4) == 3) ? 8'(w) : 8'h00);
        end
        check("b2b.overrun", 8'(overrun), 8'h00);

        // Backpressure and overrun.
        step(1, 0, 0, 0, 0);
        send_word(4'h3, 0);
        send_word(4'h6, 0);
        send_word(4'h9, 0);
        check("bp.overrun", 8'(overrun), 8'h01);
        check("bp.head0",   8'(out_),    8'h03);
        step(0, 0, 0, 0, 1);
        check("bp.head1",   8'(out_),    8'h06);
        step(0, 0, 0, 0, 1);
        check("bp.empty",   8'(out_val), 8'h00);
        check("bp.sticky",  8'(overrun), 8'h01);

        // Full queue accepts a word when the head leaves on the same edge.
        step(1, 0, 0, 0, 0);
        check("fd.reset_ovr", 8'(overrun), 8'h00);
        send_word(4'h1, 0);
        send_word(4'h2, 0);
        w4 = 4'h4;
        for (int i = 0; i < NB; i++) step(0, 1, w4[i], 0, i == NB - 1);
        check("fd.head0",   8'(out_),    8'h02);
        check("fd.overrun", 8'(overrun), 8'h00);
        step(0, 0, 0, 0, 1);
        check("fd.head1",   8'(out_),    8'h04);
        step(0, 0, 0, 0, 1);
        check("fd.empty",   8'(out_val), 8'h00);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0,
                 ($urandom % 4) != 0,
                 $urandom % 2,
                 $urandom_range(0, 31) == 0,
                 ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_nibble_deser
`default_nettype wire

// File: doc/serial_nibble_deser.md
Name: serial_nibble_deser

Overview:
- Upstream feeder for the 4-bit pairwise AND/OR/XNOR gate stage.
- Collects a serial bit stream into 4-bit words, LSB first, and buffers the completed words in a small queue.
- Presents each word on a val/rdy interface whose 4-bit data output drives the gate stage's in_ port.
- Supports frame realignment, and flags a dropped word with a sticky overrun bit.

Parameters:
- NBITS, 4, word width; the gate stage requires 4.
- QDEPTH, 2, output queue entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_sync  input  1  frame alignment pulse; restarts word assembly.
- out_val  output  1  head of queue holds a valid word.
- out_rdy  input  1  downstream accepts the word this cycle.
- out_  output  NBITS  head-of-queue word; feeds the gate stage in_.
- overrun  output  1  sticky; a completed word was dropped.
- bitcnt  output  clog2(NBITS)  debug: bits collected in the current word.

Behaviour:
- Reset (reset=1 at a rising edge):
  - bitcnt=0, shift register=0, queue empty.
  - out_val=0, out_=0, overrun=0.
  - Reset takes priority over all inputs and discards any partial word and queued words.
- Assembly:
  - On an edge with in_val=1, in_bit is written to position bitcnt of the shift register and bitcnt increments.
  - The first bit received becomes out_[0]; the last becomes out_[NBITS-1].
  - in_val=0 holds all assembly state.
- Word completion:
  - An edge with in_val=1 and bitcnt=NBITS-1 completes the word.
  - At that edge the word is formed from the stored bits plus in_bit and enqueued, and bitcnt wraps to 0.
  - Latency: out_val=1 in the cycle after the final bit edge if the queue was empty.
- in_sync handling:
  - in_sync=1 at an edge discards the partial word.
  - If in_val=1 in the same cycle, in_bit is taken as bit 0 of a new word (bitcnt becomes 1); otherwise bitcnt becomes 0.
  - in_sync never affects queued words.
- Output handshake:
  - A transfer occurs on an edge where out_val & out_rdy; the head is dequeued.
  - out_ is stable while out_val=1 and out_rdy=0.
  - out_ is driven 0 when out_val=0.
  - out_val and out_ depend only on registered state, with no combinational path from any input.
- Queue:
  - Order is FIFO.
  - Enqueue and dequeue in the same cycle are both performed, including when full: the dequeue frees the slot.
  - Count stays unchanged on a simultaneous enqueue and dequeue.
- Overflow:
  - If a word completes while the queue is full and no dequeue happens that edge, the word is dropped and overrun is set.
  - The queue contents are unchanged by a dropped word.
  - overrun clears only on reset.
- Boundary cases:
  - in_val held high indefinitely produces one word every NBITS cycles.
  - With out_rdy=1 always, the queue never exceeds one entry.

Decomposition:
- Package serial_nibble_pkg:
  - NBITS_DEFAULT=4 and QDEPTH_DEFAULT=2.
  - typedef nibble_t as logic [3:0].
- One sub-module: serial_nibble_queue.
  - Parameterized FIFO with enq_val/enq_rdy/enq_msg and deq_val/deq_rdy/deq_msg.
  - Pointers plus a count.
- The top module holds the shift register, bitcnt, sync logic and overrun flag.

Test Plan:
- Reset behaviour: assert reset mid-word after 2 bits, then send bits 1,0,1,1 with out_rdy=1 -> out_val pulses once with out_=4'b1101; the bits before reset are lost.
- Back-to-back words: stream in_val=1 for 16 cycles with bits encoding words 0x0,0x5,0xA,0xF, out_rdy=1 -> out_val=1 on cycles 5, 9, 13 and 17 with those words in order; overrun=0.
- in_val gaps: bits 1,1,0,0 with in_val=0 bubbles interleaved -> a single word 4'b0011; bitcnt does not advance during bubbles.
- Sync realignment:
  - Send bits 1,1, then in_sync=1 with in_val=1 and in_bit=0, then bits 1,0,1 -> the word is 4'b1010.
  - in_sync alone with in_val=0 -> bitcnt=0.
- Backpressure and overrun:
  - out_rdy=0; send words 0x3, 0x6, 0x9 -> the queue holds 0x3 and 0x6, 0x9 is dropped, and overrun=1.
  - Then out_rdy=1 -> 0x3 then 0x6; overrun stays 1 until reset.
- Full queue with simultaneous dequeue:
  - Queue full (0x1, 0x2), out_rdy=1 on the edge that completes 0x4 -> 0x1 is dequeued and 0x4 is enqueued.
  - Subsequent outputs are 0x2 then 0x4; overrun=0.
